// File: rtl/exp_arbiter_if.sv
// Requester-side and accelerator-side signals of the shared exponent arbiter.
// The arbiter takes the slave view; requesters plus accelerator take the master view.
interface exp_arbiter_if #(
  parameter int N = 4,
  parameter int W = 32
);
  logic [N-1:0]   req;
  logic [N*W-1:0] x_in;
  logic [N*W-1:0] a_in;
  logic [N-1:0]   grant;
  logic [N-1:0]   resp_valid;
  logic [W-1:0]   result;
  logic           busy;
  logic           exp_enable;
  logic [W-1:0]   exp_x;
  logic [W-1:0]   exp_a;
  logic [W-1:0]   exp_p;
  logic           exp_ready;

  modport slave (
    input  req, x_in, a_in, exp_p, exp_ready,
    output grant, resp_valid, result, busy, exp_enable, exp_x, exp_a
  );

  modport master (
    output req, x_in, a_in, exp_p, exp_ready,
    input  grant, resp_valid, result, busy, exp_enable, exp_x, exp_a
  );
endinterface

// File: rtl/exp_arbiter.sv
// Round-robin arbiter that time-shares one a^x accelerator among N requesters,
// latching the winner's operands and returning the accelerator result to it.
module exp_arbiter #(
  parameter int N = 4,
  parameter int W = 32
) (
  input  logic          clock,
  input  logic          reset_n,
  exp_arbiter_if.slave  bus
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [2:0] {IDLE, ISSUE, ACK, RUN, DONE} state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] cur_q, cur_d;
  logic [IW-1:0] rr_q, rr_d;
  logic [W-1:0]  result_q, result_d;
  logic [W-1:0]  expX_q, expX_d;
  logic [W-1:0]  expA_q, expA_d;
  logic          ackCnt_q, ackCnt_d;
  logic [1:0]    pulseCnt_q, pulseCnt_d;

  logic [W-1:0]  xArr [N];
  logic [W-1:0]  aArr [N];
  logic          pickFound;
  logic [IW-1:0] pickIdx;
  int            idx;

  for (genvar g = 0; g < N; g++) begin : gUnpack
    assign xArr[g] = bus.x_in[g*W +: W];
    assign aArr[g] = bus.a_in[g*W +: W];
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      cur_q      <= '0;
      rr_q       <= '0;
      result_q   <= '0;
      expX_q     <= '0;
      expA_q     <= '0;
      ackCnt_q   <= 1'b0;
      pulseCnt_q <= '0;
    end else begin
      state_q    <= state_d;
      cur_q      <= cur_d;
      rr_q       <= rr_d;
      result_q   <= result_d;
      expX_q     <= expX_d;
      expA_q     <= expA_d;
      ackCnt_q   <= ackCnt_d;
      pulseCnt_q <= pulseCnt_d;
    end
  end

  // Scan requesters starting at the round-robin pointer so the search wraps modulo N.
  always_comb begin
    state_d    = state_q;
    cur_d      = cur_q;
    rr_d       = rr_q;
    result_d   = result_q;
    expX_d     = expX_q;
    expA_d     = expA_q;
    ackCnt_d   = ackCnt_q;
    pulseCnt_d = pulseCnt_q;
    pickFound  = 1'b0;
    pickIdx    = '0;
    idx        = 0;

    for (int k = 0; k < N; k++) begin
      idx = int'(rr_q) + k;
      if (idx >= N) idx = idx - N;
      if (!pickFound && bus.req[IW'(idx)]) begin
        pickFound = 1'b1;
        pickIdx   = IW'(idx);
      end
    end

    case (state_q)
      IDLE: begin
        if (bus.exp_ready && pickFound) begin
          cur_d      = pickIdx;
          expX_d     = xArr[pickIdx];
          expA_d     = aArr[pickIdx];
          pulseCnt_d = '0;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        pulseCnt_d = pulseCnt_q + 2'd1;
        ackCnt_d   = 1'b0;
        state_d    = ACK;
      end
      // An accelerator that never drops ready is presumed to have taken the third pulse.
      ACK: begin
        if (!bus.exp_ready) begin
          state_d = RUN;
        end else if (ackCnt_q) begin
          state_d = (pulseCnt_q == 2'd3) ? RUN : ISSUE;
        end else begin
          ackCnt_d = 1'b1;
        end
      end
      RUN: begin
        if (bus.exp_ready) begin
          result_d = bus.exp_p;
          state_d  = DONE;
        end
      end
      DONE: begin
        rr_d    = (cur_q == IW'(N - 1)) ? '0 : cur_q + IW'(1);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.grant      = '0;
    bus.resp_valid = '0;
    bus.busy       = (state_q != IDLE);
    bus.exp_enable = (state_q == ISSUE);
    bus.result     = result_q;
    bus.exp_x      = expX_q;
    bus.exp_a      = expA_q;
    if (state_q != IDLE) bus.grant[cur_q] = 1'b1;
    if (state_q == DONE) bus.resp_valid[cur_q] = 1'b1;
  end
endmodule
